// File: rtl/dclab_pkg.sv
// Shared types and 7-segment constants for the up/down BCD counter.
// Segment vectors are active-low, bit0=a .. bit6=g.
package dclab_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Two-digit BCD encoding of a decimal value 0..99, used for the count limit.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-BCD codes cannot occur in the counter but show a dash if they ever do.
module bcd_to_7seg
  import dclab_pkg::*;
(
  input  bcd_digit_t  digit,
  output logic [6:0]  seg
);

  // NOTE: every path of a combinational block must assign its outputs; the
  // default arm guarantees that, so no latch is inferred.
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/updown_bcd_counter.sv
// Two-digit BCD up/down counter driven by toggle-style plus/minus lines.
// Each level change is captured for one cycle, then applied with a registered event pulse.
module updown_bcd_counter
  import dclab_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 99,
  parameter bit          WRAP      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       plus,
  input  logic       minus,
  output logic [7:0] count_bcd,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic       up_evt,
  output logic       down_evt
);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } req_state_t;

  localparam logic [7:0] MAX_BCD = to_bcd(MAX_COUNT);

  logic       plus_q;
  logic       minus_q;
  logic       inc_req;
  logic       dec_req;
  req_state_t inc_state;
  req_state_t dec_state;
  bcd_digit_t tens;
  bcd_digit_t units;
  bcd_digit_t inc_tens;
  bcd_digit_t inc_units;
  bcd_digit_t dec_tens;
  bcd_digit_t dec_units;
  logic       at_max;
  logic       at_zero;

  assign inc_req   = plus ^ plus_q;
  assign dec_req   = minus ^ minus_q;
  assign count_bcd = {tens, units};
  assign at_max    = (count_bcd == MAX_BCD);
  assign at_zero   = (count_bcd == 8'h00);

  // Per-digit BCD neighbours; tens never exceeds 9 because the limit is at most 99.
  always_comb begin
    inc_tens  = tens;
    inc_units = units + 4'd1;
    if (units == 4'd9) begin
      inc_units = 4'd0;
      inc_tens  = tens + 4'd1;
    end

    dec_tens  = tens;
    dec_units = units - 4'd1;
    if (units == 4'd0) begin
      dec_units = 4'd9;
      dec_tens  = tens - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Loading the live inputs makes a line resting at 1 look quiet on release.
      plus_q    <= plus;
      minus_q   <= minus;
      inc_state <= IDLE;
      dec_state <= IDLE;
      tens      <= 4'd0;
      units     <= 4'd0;
      up_evt    <= 1'b0;
      down_evt  <= 1'b0;
    end else begin
      plus_q    <= plus;
      minus_q   <= minus;
      inc_state <= inc_req ? APPLY : IDLE;
      dec_state <= dec_req ? APPLY : IDLE;
      up_evt    <= 1'b0;
      down_evt  <= 1'b0;

      // Opposite requests captured together cancel out.
      if (inc_state == APPLY && dec_state == IDLE) begin
        if (at_max) begin
          if (WRAP) begin
            tens   <= 4'd0;
            units  <= 4'd0;
            up_evt <= 1'b1;
          end
        end else begin
          tens   <= inc_tens;
          units  <= inc_units;
          up_evt <= 1'b1;
        end
      end else if (dec_state == APPLY && inc_state == IDLE) begin
        if (at_zero) begin
          if (WRAP) begin
            tens     <= MAX_BCD[7:4];
            units    <= MAX_BCD[3:0];
            down_evt <= 1'b1;
          end
        end else begin
          tens     <= dec_tens;
          units    <= dec_units;
          down_evt <= 1'b1;
        end
      end
    end
  end

  bcd_to_7seg u_seg_units (
    .digit (units),
    .seg   (hex0)
  );

  bcd_to_7seg u_seg_tens (
    .digit (tens),
    .seg   (hex1)
  );

endmodule

// File: tb/tb_updown_bcd_counter.sv
// Directed bench for updown_bcd_counter: a wrapping 0..99 instance and a saturating 0..59 instance.
// Inputs change 1 time unit after a rising edge; outputs are read at that same point.
module tb_updown_bcd_counter;

  logic       clk;
  logic       rst;
  logic       plus;
  logic       minus;
  logic       plus_s;
  logic       minus_s;
  logic [7:0] count_bcd;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic       up_evt;
  logic       down_evt;
  logic [7:0] count_s;
  logic [6:0] hex0_s;
  logic [6:0] hex1_s;
  logic       up_s;
  logic       down_s;

  int errors = 0;
  int checks = 0;

  updown_bcd_counter #(.MAX_COUNT(99), .WRAP(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .plus      (plus),
    .minus     (minus),
    .count_bcd (count_bcd),
    .hex0      (hex0),
    .hex1      (hex1),
    .up_evt    (up_evt),
    .down_evt  (down_evt)
  );

  updown_bcd_counter #(.MAX_COUNT(59), .WRAP(1'b0)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .plus      (plus_s),
    .minus     (minus_s),
    .count_bcd (count_s),
    .hex0      (hex0_s),
    .hex1      (hex1_s),
    .up_evt    (up_s),
    .down_evt  (down_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    plus    = 1'b1;
    minus   = 1'b0;
    plus_s  = 1'b0;
    minus_s = 1'b0;
    repeat (3) tick();
    checks++;
    if (count_bcd !== 8'h00 || up_evt !== 1'b0 || down_evt !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: count=%h up=%b down=%b, want 00 0 0", count_bcd, up_evt, down_evt);
    end
    checks++;
    if (hex0 !== 7'b1000000 || hex1 !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_hex: hex1=%b hex0=%b, want 1000000 1000000", hex1, hex0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if (up_evt !== 1'b0 || down_evt !== 1'b0 || count_bcd !== 8'h00) begin
        errors++;
        $display("FAIL release_quiet cyc%0d: count=%h up=%b down=%b, want 00 0 0", c, count_bcd, up_evt, down_evt);
      end
    end
    checks++;
    if (hex0 !== 7'b1000000 || hex1 !== 7'b1000000) begin
      errors++;
      $display("FAIL release_hex: hex1=%b hex0=%b, want 1000000 1000000", hex1, hex0);
    end
  endtask

  // One toggle each way of the plus line; the pulse lands exactly two edges after the toggle.
  task automatic test_single_steps();
    logic [7:0] want [2];
    want[0] = 8'h01;
    want[1] = 8'h02;
    for (int s = 0; s < 2; s++) begin
      plus = ~plus;
      for (int c = 1; c <= 4; c++) begin
        tick();
        checks++;
        if (up_evt !== (c == 2) || down_evt !== 1'b0) begin
          errors++;
          $display("FAIL step%0d_evt cyc%0d: up=%b down=%b, want %b 0", s, c, up_evt, down_evt, (c == 2));
        end
        if (c == 1) begin
          checks++;
          if (count_bcd !== want[s] - 8'h01) begin
            errors++;
            $display("FAIL step%0d_latency: count=%h, want %h", s, count_bcd, want[s] - 8'h01);
          end
        end
      end
      checks++;
      if (count_bcd !== want[s]) begin
        errors++;
        $display("FAIL step%0d_count: count=%h, want %h", s, count_bcd, want[s]);
      end
    end
  endtask

  task automatic test_digit_carry();
    repeat (7) begin
      plus = ~plus;
      tick();
      tick();
    end
    checks++;
    if (count_bcd !== 8'h09 || hex0 !== 7'b0010000) begin
      errors++;
      $display("FAIL reach_09: count=%h hex0=%b, want 09 0010000", count_bcd, hex0);
    end
    plus = ~plus;
    tick();
    tick();
    checks++;
    if (count_bcd !== 8'h10 || up_evt !== 1'b1) begin
      errors++;
      $display("FAIL carry_10: count=%h up=%b, want 10 1", count_bcd, up_evt);
    end
    checks++;
    if (hex1 !== 7'b1111001 || hex0 !== 7'b1000000) begin
      errors++;
      $display("FAIL carry_hex: hex1=%b hex0=%b, want 1111001 1000000", hex1, hex0);
    end
    minus = ~minus;
    tick();
    tick();
    checks++;
    if (count_bcd !== 8'h09 || down_evt !== 1'b1 || up_evt !== 1'b0) begin
      errors++;
      $display("FAIL borrow_09: count=%h down=%b up=%b, want 09 1 0", count_bcd, down_evt, up_evt);
    end
    checks++;
    if (hex1 !== 7'b1000000 || hex0 !== 7'b0010000) begin
      errors++;
      $display("FAIL borrow_hex: hex1=%b hex0=%b, want 1000000 0010000", hex1, hex0);
    end
  endtask

  task automatic test_wrap();
    // Nine back-to-back decrements from 09 land on 00.
    repeat (9) begin
      minus = ~minus;
      tick();
    end
    tick();
    checks++;
    if (count_bcd !== 8'h00 || down_evt !== 1'b1) begin
      errors++;
      $display("FAIL down_to_00: count=%h down=%b, want 00 1", count_bcd, down_evt);
    end
    minus = ~minus;
    tick();
    tick();
    checks++;
    if (count_bcd !== 8'h99 || down_evt !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down: count=%h down=%b, want 99 1", count_bcd, down_evt);
    end
    checks++;
    if (hex1 !== 7'b0010000 || hex0 !== 7'b0010000) begin
      errors++;
      $display("FAIL wrap_hex: hex1=%b hex0=%b, want 0010000 0010000", hex1, hex0);
    end
    plus = ~plus;
    tick();
    tick();
    checks++;
    if (count_bcd !== 8'h00 || up_evt !== 1'b1) begin
      errors++;
      $display("FAIL wrap_up: count=%h up=%b, want 00 1", count_bcd, up_evt);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 42; i++) begin
      plus = ~plus;
      tick();
      if (up_evt === 1'b1) pulses++;
    end
    tick();
    if (up_evt === 1'b1) pulses++;
    checks++;
    if (count_bcd !== 8'h42) begin
      errors++;
      $display("FAIL b2b_count: count=%h, want 42", count_bcd);
    end
    checks++;
    if (pulses != 42) begin
      errors++;
      $display("FAIL b2b_pulses: pulses=%0d, want 42", pulses);
    end
    tick();
    checks++;
    if (up_evt !== 1'b0 || count_bcd !== 8'h42) begin
      errors++;
      $display("FAIL b2b_settle: count=%h up=%b, want 42 0", count_bcd, up_evt);
    end
  endtask

  task automatic test_simultaneous();
    plus  = ~plus;
    minus = ~minus;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (up_evt !== 1'b0 || down_evt !== 1'b0 || count_bcd !== 8'h42) begin
        errors++;
        $display("FAIL cancel cyc%0d: count=%h up=%b down=%b, want 42 0 0", c, count_bcd, up_evt, down_evt);
      end
    end
  endtask

  task automatic test_reset_mid();
    plus = ~plus;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (count_bcd !== 8'h00 || up_evt !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%h up=%b, want 00 0", count_bcd, up_evt);
    end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (up_evt !== 1'b0 || count_bcd !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_after cyc%0d: count=%h up=%b, want 00 0", c, count_bcd, up_evt);
      end
    end
  endtask

  task automatic test_saturate();
    minus_s = ~minus_s;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (down_s !== 1'b0 || count_s !== 8'h00) begin
        errors++;
        $display("FAIL sat_low cyc%0d: count=%h down=%b, want 00 0", c, count_s, down_s);
      end
    end
    repeat (59) begin
      plus_s = ~plus_s;
      tick();
    end
    tick();
    checks++;
    if (count_s !== 8'h59 || hex1_s !== 7'b0010010 || hex0_s !== 7'b0010000) begin
      errors++;
      $display("FAIL sat_reach_59: count=%h hex1=%b hex0=%b, want 59 0010010 0010000", count_s, hex1_s, hex0_s);
    end
    plus_s = ~plus_s;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (up_s !== 1'b0 || count_s !== 8'h59) begin
        errors++;
        $display("FAIL sat_high cyc%0d: count=%h up=%b, want 59 0", c, count_s, up_s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_steps();
    test_digit_carry();
    test_wrap();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_bcd_counter.md
Name: updown_bcd_counter

Overview:
- Consumes the `plus`/`minus` toggle outputs of the push-button one-shot stage.
  - Each press flips the corresponding line once, so any level change is one event.
- Converts each toggle into an increment or decrement of a two-digit BCD count, 00..MAX_COUNT.
- Drives two active-low 7-segment digits on the board.
- Sits directly downstream of the one-shot, in the same `clk` domain.

Parameters:
- MAX_COUNT, 99, upper count limit in decimal. Legal range 1..99; the limit is also encoded in BCD internally.
- WRAP, 1, 1 = wrap around at the limits (MAX_COUNT->0 on up, 0->MAX_COUNT on down); 0 = saturate at 0 and MAX_COUNT.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- plus  input  1  up toggle from the one-shot; each level change is one increment request.
- minus  input  1  down toggle from the one-shot; each level change is one decrement request.
- count_bcd  output  8  current count; [7:4] = tens, [3:0] = units, each 0..9.
- hex0  output  7  units digit segments, active-low; bit0=a .. bit6=g.
- hex1  output  7  tens digit segments, active-low, same encoding.
- up_evt  output  1  one-cycle pulse, registered, high in the cycle the count has just been changed by an increment.
- down_evt  output  1  one-cycle pulse, same timing, for a decrement.

Behaviour:
- Edge capture:
  - Registers plus_q/minus_q sample plus/minus every cycle.
  - inc_req = plus ^ plus_q; dec_req = minus ^ minus_q.
- Reset:
  - While rst=1: count_bcd=8'h00, up_evt=down_evt=0.
  - plus_q/minus_q load the current plus/minus, so a toggle line sitting at 1 generates no event when rst is released.
  - hex0=hex1=7'b1000000 ("0") during and after reset.
- Latency:
  - A toggle present on the input before edge N is captured at edge N.
  - count_bcd and the matching evt pulse update at edge N+1, one cycle later.
  - hex outputs are combinational from count_bcd and follow in the same cycle.
- Arithmetic, BCD per digit:
  - Increment: units 9->0 with carry into tens; otherwise units+1.
  - Decrement: units 0->9 with borrow from tens; otherwise units-1.
  - Digits never hold A..F.
- Limits:
  - Increment at MAX_COUNT: WRAP=1 -> 00, up_evt=1; WRAP=0 -> unchanged, up_evt=0.
  - Decrement at 00: WRAP=1 -> MAX_COUNT, down_evt=1; WRAP=0 -> unchanged, down_evt=0.
- Simultaneous events: inc_req and dec_req in the same cycle cancel. The count is unchanged and both evt outputs are 0.
- Back-to-back toggles on consecutive cycles are each counted; there is no rate limit in this stage.
- Reset mid-operation: a pending captured request is discarded; rst has priority over all updates.
- State machine: per direction, two states.
  - IDLE: no request pending.
  - APPLY: request captured; the count updates on the next edge.
  - Transition condition: IDLE->APPLY on req; APPLY->IDLE always, or stays in APPLY if a new req is captured.
  - Equivalently, the evt outputs are the registered, qualified request.
- 7-seg encoding, active-low, gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any non-BCD value (unreachable) decodes to 0111111 (segment g only).

Decomposition:
- Package dclab_pkg holds:
  - SEG_BLANK, SEG_DASH, and the SEG_DIGIT constant array 0..9.
  - The BCD digit typedef (4-bit).
- Sub-module bcd_to_7seg: one 4-bit digit in, 7-bit active-low segments out, purely combinational; instantiated twice.
- The BCD increment/decrement logic stays in updown_bcd_counter.

Test Plan:
- Reset with plus=1, minus=0, release rst, hold inputs -> count_bcd stays 8'h00, no evt pulse, hex0=hex1=7'b1000000.
- Toggle plus 0->1 at cycle 10, then 1->0 at cycle 20 -> count 8'h01 at cycle 12 and 8'h02 at cycle 22; up_evt pulses at cycles 12 and 22 only.
- From count 8'h09, one plus toggle -> 8'h10, hex1=1111001, hex0=1000000. From 8'h10, one minus toggle -> 8'h09.
- WRAP=1, MAX_COUNT=99:
  - At 8'h99, plus toggle -> 8'h00, up_evt=1.
  - At 8'h00, minus toggle -> 8'h99.
- WRAP=0, MAX_COUNT=59:
  - At 8'h59, plus toggle -> stays 8'h59, up_evt=0.
  - At 8'h00, minus toggle -> stays 8'h00, down_evt=0.
- Plus and minus toggled in the same cycle at count 8'h42 -> count stays 8'h42, no evt.
- Assert rst on the cycle after a plus toggle is captured -> count 8'h00, no up_evt.
